// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared state encoding, frame geometry and error-bit layout for the boot loader.
package inst_loader_pkg;
   typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int E_LEN          = 0;
   localparam int E_CSUM         = 1;
   localparam int E_TMO          = 2;
   localparam int ERR_W          = 3;
endpackage

// File: rtl/inst_loader_timer.sv
// inst_loader_timer: saturating idle counter; expired fires on the cycle whose edge completes TIMEOUT_CYC idle cycles.
module inst_loader_timer #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (rst || clr || !en) cnt <= '0;
      else if (cnt != CW'(TIMEOUT_CYC)) cnt <= cnt + CW'(1);
   assign expired = en && !clr && cnt >= CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time InstCatch writer; loads a length-framed, XOR-checked image and holds the core in reset until it verifies.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   input  logic              reload,
   output logic              ic_wren,
   output logic [ADDR_W-1:0] ic_wraddr,
   output logic [31:0]       ic_wrdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   output logic              err_csum,
   output logic              err_timeout
);
   localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;
   state_t            state, state_n;
   logic [ERR_W-1:0]  err, err_n;
   logic [7:0]        len_lo, xsum;
   logic [15:0]       n;
   logic [ADDR_W-1:0] widx, last;
   logic [1:0]        lane;
   logic [23:0]       acc;
   logic              hs, expired, word_end, rearm;
   logic              s_ready_n, busy_n, done_n, core_rst_n;

   assign hs          = s_valid && s_ready;
   assign n           = {s_data, len_lo};
   assign word_end    = state == DATA && hs && lane == 2'(BYTES_PER_WORD - 1);
   assign rearm       = (state == DONE || state == ERR) && reload;
   assign err_len     = err[E_LEN];
   assign err_csum    = err[E_CSUM];
   assign err_timeout = err[E_TMO];

   inst_loader_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk(clk), .rst(rst), .en(busy), .clr(hs), .expired(expired)
   );

   always_ff @(posedge clk)
      if (rst) begin
         state    <= LEN_LO;
         err      <= '0;
         s_ready  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         core_rst <= 1'b1;
      end else begin
         state    <= state_n;
         err      <= err_n;
         s_ready  <= s_ready_n;
         busy     <= busy_n;
         done     <= done_n;
         core_rst <= core_rst_n;
      end

   always_comb begin
      state_n = state;
      err_n   = err;
      case (state)
         LEN_LO: if (hs) state_n = LEN_HI;
         LEN_HI: if (hs) begin
            state_n      = (n == 16'd0 || {1'b0, n} > MAX_N) ? ERR : DATA;
            err_n[E_LEN] = state_n == ERR;
         end
         DATA:   if (word_end && widx == last) state_n = CSUM;
         CSUM:   if (hs) begin
            state_n       = s_data == xsum ? DONE : ERR;
            err_n[E_CSUM] = s_data != xsum;
         end
         DONE, ERR: if (reload) begin
            state_n = LEN_LO;
            err_n   = '0;
         end
         default: state_n = LEN_LO;
      endcase
      if (expired) begin
         state_n      = ERR;
         err_n[E_TMO] = 1'b1;
      end
   end

   always_comb begin
      s_ready_n  = state_n inside {LEN_LO, LEN_HI, DATA, CSUM};
      busy_n     = state_n inside {LEN_HI, DATA, CSUM};
      done_n     = state_n == DONE;
      core_rst_n = state_n != DONE;
   end

   // Lanes shift in from the top so the 4th byte completes a little-endian word.
   always_ff @(posedge clk)
      if (rst) begin
         ic_wren   <= 1'b0;
         ic_wraddr <= '0;
         ic_wrdata <= '0;
         len_lo    <= '0;
         xsum      <= '0;
         widx      <= '0;
         last      <= '0;
         lane      <= '0;
         acc       <= '0;
      end else begin
         ic_wren <= word_end;
         if (rearm) begin
            len_lo <= '0;
            xsum   <= '0;
            widx   <= '0;
            lane   <= '0;
         end
         if (hs && state != CSUM) xsum <= xsum ^ s_data;
         if (hs && state == LEN_LO) len_lo <= s_data;
         if (hs && state == LEN_HI) begin
            last <= ADDR_W'(n - 16'd1);
            widx <= '0;
            lane <= '0;
         end
         if (hs && state == DATA) begin
            lane <= lane + 2'd1;
            acc  <= {s_data, acc[23:8]};
         end
         if (word_end) begin
            ic_wraddr <= widx;
            ic_wrdata <= {s_data, acc};
            widx      <= widx + ADDR_W'(1);
         end
      end
endmodule
